// File: rtl/mips32_program_loader.sv
// mips32_program_loader: byte-stream boot loader that fills MEM, then releases the MIPS32 core at START_PC.
// Optional LOADER_CHECKSUM_EN: a trailing XOR checksum word must match before the core is started.
module mips32_program_loader #(
  parameter int          AW       = 10,
  parameter logic [31:0] START_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          cpu_start,
  output logic [31:0]   cpu_pc,
  input  logic          restart,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_written
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, START, DONE, ERR, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, START, DONE, ERR} state_t;
`endif
  state_t        state, nxt;
  logic [1:0]    cnt;
  logic [23:0]   sh;
  logic [15:0]   rem;
  logic [AW-1:0] ptr;
  logic [31:0]   word;
  logic          acc, wdone, hdr_bad, nxt_csum;
  assign acc     = s_valid && s_ready && !restart;
  assign wdone   = acc && cnt == 2'd3;
  assign word    = {sh, s_data};
  assign hdr_bad = ({1'b0, word[31:16]} + {1'b0, word[15:0]}) > (17'd1 << AW);
  assign cpu_pc  = START_PC;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t TERM = CSUM;
  logic [31:0] csum;
  assign nxt_csum = nxt == CSUM;
`else
  localparam state_t TERM = START;
  assign nxt_csum = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = HDR;
      HDR:     if (wdone) nxt = word[15:0] == 16'd0 ? TERM : hdr_bad ? ERR : DATA;
      DATA:    if (wdone && rem == 16'd1) nxt = HDR;
`ifdef LOADER_CHECKSUM_EN
      CSUM:    if (wdone) nxt = word == csum ? START : ERR;
`endif
      START:   nxt = DONE;
      default: nxt = state;
    endcase
    if (restart) nxt = IDLE;
  end
  // Status outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      sh            <= '0;
      rem           <= '0;
      ptr           <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
      s_ready       <= 1'b0;
      busy          <= 1'b0;
      cpu_hold      <= 1'b1;
      cpu_start     <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      state         <= nxt;
      s_ready       <= nxt == HDR || nxt == DATA || nxt_csum;
      busy          <= nxt == HDR || nxt == DATA || nxt_csum || nxt == START;
      cpu_hold      <= !(nxt == START || nxt == DONE);
      cpu_start     <= nxt == START;
      done          <= nxt == DONE;
      error         <= nxt == ERR;
      cnt           <= restart ? 2'd0 : cnt + 2'(acc);
      mem_we        <= state == DATA && wdone;
      words_written <= restart ? '0 : words_written + 16'(mem_we && words_written != 16'hFFFF);
      if (acc) sh <= word[23:0];
      if (state == HDR && wdone) begin
        ptr <= word[16 +: AW];
        rem <= word[15:0];
      end
      if (state == DATA && wdone) begin
        mem_addr  <= ptr;
        mem_wdata <= word;
        ptr       <= ptr + 1'b1;
        rem       <= rem - 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      csum <= (restart || state == IDLE) ? '0 : (state == DATA && wdone) ? csum ^ word : csum;
`endif
    end
  end
endmodule
